// File: rtl/mac_vec_arbiter.sv
// Vector-granular arbiter/sequencer sharing one MAC between two requesters.
// Define MAC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin per vector.
module mac_vec_arbiter #(
    parameter int WIDTH   = 10,
    parameter int VEC_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    output logic [WIDTH-1:0]     mac_a,
    output logic [WIDTH-1:0]     mac_b,
    output logic                 mac_valid_in,
    output logic                 mac_clr,
    input  logic [2*WIDTH-1:0]   mac_f,
    input  logic                 mac_valid_out,
    output logic [2*WIDTH-1:0]   res_f,
    output logic                 res_id,
    output logic                 res_valid
);

    localparam int CW = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        CLEAR
    } state_t;

    state_t               r_state;
    logic                 r_grant;
    logic [CW-1:0]        r_in_cnt;
    logic [CW-1:0]        r_out_cnt;
    logic [WIDTH-1:0]     r_mac_a;
    logic [WIDTH-1:0]     r_mac_b;
    logic                 r_mac_valid_in;
    logic                 r_mac_clr;
    logic [2*WIDTH-1:0]   r_res_f;
    logic                 r_res_id;
    logic                 r_res_valid;
`ifndef MAC_ARB_FIXED_PRIO_EN
    logic                 r_prio;
`endif

    logic                 w_ready0;
    logic                 w_ready1;
    logic                 w_acc;
    logic                 w_pick;
    logic                 w_out_hit;
    logic                 w_last_in;
    logic                 w_last_out;
    logic [WIDTH-1:0]     w_beat_a;
    logic [WIDTH-1:0]     w_beat_b;

    // Ready comes only from registered state so it never loops back through reqN_valid.
    always_comb begin
        w_ready0   = (r_state == STREAM) && !r_grant && (r_in_cnt < CW'(VEC_LEN));
        w_ready1   = (r_state == STREAM) &&  r_grant && (r_in_cnt < CW'(VEC_LEN));
        w_acc      = (w_ready0 && req0_valid) || (w_ready1 && req1_valid);
        w_beat_a   = r_grant ? req1_a : req0_a;
        w_beat_b   = r_grant ? req1_b : req0_b;
        w_out_hit  = mac_valid_out && ((r_state == STREAM) || (r_state == DRAIN));
        w_last_in  = w_acc && (r_in_cnt == CW'(VEC_LEN - 1));
        w_last_out = w_out_hit && (r_out_cnt == CW'(VEC_LEN - 1));
`ifdef MAC_ARB_FIXED_PRIO_EN
        w_pick     = !req0_valid;
`else
        w_pick     = (req0_valid && req1_valid) ? r_prio : req1_valid;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_grant        <= 1'b0;
            r_in_cnt       <= '0;
            r_out_cnt      <= '0;
            r_mac_a        <= '0;
            r_mac_b        <= '0;
            r_mac_valid_in <= 1'b0;
            r_mac_clr      <= 1'b1;
            r_res_f        <= '0;
            r_res_id       <= 1'b0;
            r_res_valid    <= 1'b0;
`ifndef MAC_ARB_FIXED_PRIO_EN
            r_prio         <= 1'b0;
`endif
        end else begin
            r_mac_valid_in <= w_acc;
            r_mac_clr      <= 1'b0;
            r_res_valid    <= 1'b0;
            if (w_acc) begin
                r_mac_a <= w_beat_a;
                r_mac_b <= w_beat_b;
            end
            case (r_state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_grant <= w_pick;
                        r_state <= STREAM;
                    end
                end
                STREAM, DRAIN: begin
                    if (w_acc)
                        r_in_cnt <= r_in_cnt + CW'(1);
                    if (w_last_in)
                        r_state <= DRAIN;
                    if (w_out_hit)
                        r_out_cnt <= r_out_cnt + CW'(1);
                    if (w_last_out) begin
                        r_res_f     <= mac_f;
                        r_res_id    <= r_grant;
                        r_res_valid <= 1'b1;
                        r_mac_clr   <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_in_cnt  <= '0;
                    r_out_cnt <= '0;
`ifndef MAC_ARB_FIXED_PRIO_EN
                    r_prio    <= ~r_grant;
`endif
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready   = w_ready0;
    assign req1_ready   = w_ready1;
    assign mac_a        = r_mac_a;
    assign mac_b        = r_mac_b;
    assign mac_valid_in = r_mac_valid_in;
    assign mac_clr      = r_mac_clr;
    assign res_f        = r_res_f;
    assign res_id       = r_res_id;
    assign res_valid    = r_res_valid;

endmodule

// File: tb/tb_mac_vec_arbiter.sv
// Bench for mac_vec_arbiter with a behavioural MAC; directed scenarios then random vectors.
module tb_mac_vec_arbiter;

    localparam int W  = 10;
    localparam int VL = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]     mac_a, mac_b;
    logic             mac_valid_in, mac_clr;
    logic [2*W-1:0]   mac_f;
    logic             mac_valid_out;
    logic [2*W-1:0]   res_f;
    logic             res_id, res_valid;

    always #5 clk = ~clk;

    mac_vec_arbiter #(.WIDTH(W), .VEC_LEN(VL)) dut (
        .clk(clk), .reset(reset),
        .req0_a(req0_a), .req0_b(req0_b), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clr(mac_clr),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .res_f(res_f), .res_id(res_id), .res_valid(res_valid)
    );

    // Behavioural MAC: synchronous clear, one-cycle registered accumulate.
    logic signed [2*W-1:0] mac_acc = '0;
    logic                  mac_vout = 1'b0;
    logic signed [2*W-1:0] pa, pb;
    assign pa    = {{W{mac_a[W-1]}}, mac_a};
    assign pb    = {{W{mac_b[W-1]}}, mac_b};
    assign mac_f = mac_acc;
    assign mac_valid_out = mac_vout;
    always @(posedge clk) begin
        if (mac_clr) begin
            mac_acc  <= '0;
            mac_vout <= 1'b0;
        end else begin
            mac_vout <= mac_valid_in;
            if (mac_valid_in) mac_acc <= mac_acc + pa * pb;
        end
    end

    int res_f_q[$];
    int res_id_q[$];
    int vin_cnt = 0, clr_cnt = 0, both_rdy = 0, r1rdy_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (res_valid) begin
                res_f_q.push_back(int'($signed(res_f)));
                res_id_q.push_back(int'(res_id));
            end
            if (mac_valid_in) vin_cnt++;
            if (mac_clr) clr_cnt++;
            if (req0_ready && req1_ready) both_rdy++;
            if (req1_ready) r1rdy_cnt++;
        end
    end

    int errors = 0;
    int checks = 0;
    int qa0[$], qb0[$], qa1[$], qb1[$], e0[$], e1[$];
    int mode0 = 0, mode1 = 0;
    bit tog0 = 1'b1, tog1 = 1'b1;
    int acc0_cnt = 0, acc1_cnt = 0;
    bit smp_rdy0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap(input longint s);
        logic signed [2*W-1:0] t;
        t = s[2*W-1:0];
        return int'(t);
    endfunction

    function automatic bit want(input int mode, input bit tog);
        if (mode == 0) return 1'b1;
        if (mode == 1) return tog;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic push_vec(input int r, input int va[VL], input int vb[VL]);
        longint sum = 0;
        for (int i = 0; i < VL; i++) begin
            sum += longint'(va[i]) * longint'(vb[i]);
            if (r == 0) begin qa0.push_back(va[i]); qb0.push_back(vb[i]); end
            else        begin qa1.push_back(va[i]); qb1.push_back(vb[i]); end
        end
        if (r == 0) e0.push_back(wrap(sum));
        else        e1.push_back(wrap(sum));
    endtask

    task automatic update_drivers();
        if (qa0.size() > 0 && want(mode0, tog0)) begin
            req0_valid = 1'b1; req0_a = W'(qa0[0]); req0_b = W'(qb0[0]);
        end else begin
            req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
        end
        if (qa1.size() > 0 && want(mode1, tog1)) begin
            req1_valid = 1'b1; req1_a = W'(qa1[0]); req1_b = W'(qb1[0]);
        end else begin
            req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
        end
        tog0 = ~tog0;
        tog1 = ~tog1;
    endtask

    task automatic step();
        bit a0, a1;
        @(negedge clk);
        smp_rdy0 = req0_ready;
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (a0) begin void'(qa0.pop_front()); void'(qb0.pop_front()); acc0_cnt++; end
        if (a1) begin void'(qa1.pop_front()); void'(qb1.pop_front()); acc1_cnt++; end
        update_drivers();
    endtask

    task automatic wait_results(input string tag, input int target, input int budget);
        int n = 0;
        while (res_f_q.size() < target && n < budget) begin
            step();
            n++;
        end
        check(tag, res_f_q.size(), target);
    endtask

    task automatic clear_stim();
        qa0.delete(); qb0.delete(); qa1.delete(); qb1.delete(); e0.delete(); e1.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        mode0 = 0; mode1 = 0; tog0 = 1'b1; tog1 = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy0"}, int'(req0_ready), 0);
        check({tag, "_rdy1"}, int'(req1_ready), 0);
        check({tag, "_vin"}, int'(mac_valid_in), 0);
        check({tag, "_mac_a"}, int'(mac_a), 0);
        check({tag, "_mac_b"}, int'(mac_b), 0);
        check({tag, "_clr"}, int'(mac_clr), 1);
        check({tag, "_res_f"}, int'(res_f), 0);
        check({tag, "_res_id"}, int'(res_id), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
    endtask

    task automatic do_reset();
        clear_stim();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        int base, snap_v, snap_c, snap_a, snap_r1;
        int va[VL], vb[VL];
        clear_stim();
        reset = 1'b0;
        #12;
        check_reset_outputs("por");

        // Req0 holds valid for 3 vectors while req1 waits with one vector.
        do_reset();
        check("idle_clr", int'(mac_clr), 0);
        base = res_f_q.size();
        for (int v = 0; v < 3; v++) push_vec(0, '{2, 2, 2, 2}, '{3, 3, 3, 3});
        push_vec(1, '{1, 1, 1, 1}, '{1, 1, 1, 1});
        wait_results("rr_wait", base + 4, 400);
        if (res_f_q.size() >= base + 4) begin
            check("rr_id0", res_id_q[base], 0);   check("rr_f0", res_f_q[base], 24);
            check("rr_id1", res_id_q[base+1], 1); check("rr_f1", res_f_q[base+1], 4);
            check("rr_id2", res_id_q[base+2], 0); check("rr_f2", res_f_q[base+2], 24);
            check("rr_id3", res_id_q[base+3], 0); check("rr_f3", res_f_q[base+3], 24);
        end

        // Req0 alone, dot product 70, latency of the first grant.
        do_reset();
        snap_v = vin_cnt; snap_c = clr_cnt;
        base = res_f_q.size();
        push_vec(0, '{1, 2, 3, 4}, '{5, 6, 7, 8});
        step();
        @(negedge clk);
        check("ready_before_grant", int'(req0_ready), 0);
        step();
        check("ready_after_grant", int'(smp_rdy0), 1);
        wait_results("solo_wait", base + 1, 100);
        repeat (6) step();
        check("solo_cnt", res_f_q.size(), base + 1);
        if (res_f_q.size() > base) begin
            check("solo_f", res_f_q[base], 70);
            check("solo_id", res_id_q[base], 0);
        end
        check("solo_vin_pulses", vin_cnt - snap_v, 4);
        check("solo_clr_pulses", clr_cnt - snap_c, 1);

        // Both valid from reset; req1 must stay unready during req0's vector.
        do_reset();
        base = res_f_q.size();
        snap_r1 = r1rdy_cnt;
        push_vec(0, '{1, 1, 1, 1}, '{2, 2, 2, 2});
        push_vec(1, '{-3, -3, -3, -3}, '{4, 4, 4, 4});
        wait_results("both_wait1", base + 1, 100);
        check("r1_ready_during_r0", r1rdy_cnt - snap_r1, 0);
        wait_results("both_wait2", base + 2, 100);
        if (res_f_q.size() >= base + 2) begin
            check("both_id0", res_id_q[base], 0);   check("both_f0", res_f_q[base], 8);
            check("both_id1", res_id_q[base+1], 1); check("both_f1", res_f_q[base+1], -48);
        end
        repeat (3) step();

        // Reset mid-vector after two beats; partial vector leaves no trace.
        snap_a = acc0_cnt;
        push_vec(0, '{5, 5, 5, 5}, '{5, 5, 5, 5});
        for (int n = 0; n < 30 && acc0_cnt - snap_a < 2; n++) step();
        check("mid_accepts", acc0_cnt - snap_a, 2);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        clear_stim();
        base = res_f_q.size();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        push_vec(0, '{1, 1, 1, 1}, '{1, 1, 1, 1});
        wait_results("post_rst_wait", base + 1, 100);
        repeat (6) step();
        check("post_rst_cnt", res_f_q.size(), base + 1);
        if (res_f_q.size() > base) check("post_rst_f", res_f_q[base], 4);

        // Alternating valid: grant held over gaps, exactly four accepts.
        do_reset();
        mode0 = 1;
        base = res_f_q.size();
        snap_a = acc0_cnt;
        push_vec(0, '{1, 2, 3, 4}, '{1, 2, 3, 4});
        wait_results("gap_wait", base + 1, 100);
        repeat (4) step();
        check("gap_accepts", acc0_cnt - snap_a, 4);
        if (res_f_q.size() > base) begin
            check("gap_f", res_f_q[base], 30);
            check("gap_id", res_id_q[base], 0);
        end

        // Random vectors with random valid gaps on both requesters.
        do_reset();
        mode0 = 2; mode1 = 2;
        base = res_f_q.size();
        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < VL; i++) begin
                    va[i] = int'($urandom_range(0, 1023)) - 512;
                    vb[i] = int'($urandom_range(0, 1023)) - 512;
                end
                push_vec(r, va, vb);
            end
        end
        wait_results("rand_wait", base + 12, 3000);
        for (int i = base; i < res_f_q.size(); i++) begin
            if (res_id_q[i] == 0) begin
                check("rand_avail0", int'(e0.size() > 0), 1);
                if (e0.size() > 0) check("rand_f0", res_f_q[i], e0.pop_front());
            end else begin
                check("rand_avail1", int'(e1.size() > 0), 1);
                if (e1.size() > 0) check("rand_f1", res_f_q[i], e1.pop_front());
            end
        end
        check("rand_left0", e0.size(), 0);
        check("rand_left1", e1.size(), 0);
        check("both_ready_cycles", both_rdy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_vec_arbiter.md
# mac_vec_arbiter

Vector-granular arbiter and sequencer sharing one part3_mac datapath between two requesters. Each requester streams VEC_LEN signed operand pairs over a valid/ready handshake. The block forwards the pairs to the MAC, collects the accumulated dot product, and returns it tagged with the requester id. It then clears the MAC before granting the next vector.

## Interface
- WIDTH, 10, operand width in bits (signed).
- VEC_LEN, 4, operand pairs per vector (≥1).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req0_a, req0_b  input  WIDTH  requester 0 operands (signed).
- req0_valid  input  1  requester 0 operand pair valid.
- req0_ready  output  1  requester 0 pair accepted when valid&ready.
- req1_a, req1_b, req1_valid  input  WIDTH/WIDTH/1  requester 1, same meaning.
- req1_ready  output  1  requester 1 accept.
- mac_a, mac_b  output  WIDTH  operands to MAC.
- mac_valid_in  output  1  MAC operand valid.
- mac_clr  output  1  drives the MAC's synchronous active-high reset.
- mac_f  input  2*WIDTH  MAC accumulator (signed).
- mac_valid_out  input  1  MAC result valid.
- res_f  output  2*WIDTH  completed dot product.
- res_id  output  1  requester owning res_f.
- res_valid  output  1  one-cycle result strobe.

## Operation
- FSM states: IDLE, STREAM, DRAIN, CLEAR.
- IDLE: when any reqN_valid is high, latch grant and go to STREAM. If both are high, grant the requester selected by the priority pointer. The pointer resets to 0.
- STREAM: reqN_ready = (grant==N) && (in_cnt < VEC_LEN). The ungranted ready is always 0.
- Each accepted beat registers its operands to mac_a/mac_b and sets mac_valid_in=1 on the next cycle. With no beat, mac_valid_in=0 and mac_a/mac_b hold.
- A valid gap mid-vector stalls. The grant is held and there is no timeout.
- When the VEC_LEN-th beat is accepted, go to DRAIN. Ready is 0 from the next cycle.
- Count mac_valid_out pulses in STREAM and DRAIN (out_cnt). On the pulse that makes out_cnt == VEC_LEN:
  - register mac_f into res_f;
  - set res_id = grant and res_valid = 1 next cycle;
  - go to CLEAR.
- CLEAR: mac_clr = 1 for exactly one cycle. Reset both counters, move the priority pointer to the other requester, then go to IDLE.
- mac_valid_out while in IDLE or CLEAR is ignored.
- res_f is not altered: it is the MAC's 2*WIDTH value verbatim, so any wrap is the MAC's behaviour.
- Counters are $clog2(VEC_LEN+1) bits and cannot exceed VEC_LEN.

## Timing
- Reset values: state IDLE, pointer 0, counters 0, req0_ready = req1_ready = 0, mac_valid_in = 0, mac_a = mac_b = 0, res_f = 0, res_id = 0, res_valid = 0, mac_clr = 1.
- mac_clr = 1 at reset guarantees the MAC is cleared at the first edge after release. In IDLE, mac_clr = 0.
- Ready is decoded from registered state only. It never depends combinationally on reqN_valid.
- Earliest grant: a valid sampled in IDLE at edge k gives ready high during cycle k+1.
- Beat accepted at edge t gives mac_valid_in high in cycle t+1.
- Final mac_valid_out sampled at edge u gives res_valid in cycle u+1 and mac_clr in cycle u+1. The state returns to IDLE at edge u+2.
- The next grant therefore has ready at the earliest in cycle u+3.
- Reset asserted mid-vector: all outputs take reset values immediately and the partial vector is discarded with no res_valid. The next vector's result must contain no residue.

## Configuration
- MAC_ARB_FIXED_PRIO_EN defined: on contention in IDLE, requester 0 always wins and the pointer is unused.
- Undefined (default): round-robin at vector granularity, with the pointer toggled in CLEAR.

## Test plan
- Block connected to part3_mac, VEC_LEN=4, default build.
- Req0 only, a = {1,2,3,4}, b = {5,6,7,8}, back-to-back -> one res_valid with res_id=0 and res_f=70. mac_valid_in pulses exactly 4 times, followed by one mac_clr pulse.
- Both valid from reset: req0 a=1,b=2 ×4; req1 a=-3,b=4 ×4 -> res (id0, 8) then (id1, -48). req1_ready stays 0 throughout req0's vector.
- Req0 holds valid for 3 vectors (a=2,b=3) while req1 waits (a=1,b=1) -> order id0 = 24, id1 = 4, id0 = 24. With MAC_ARB_FIXED_PRIO_EN the order is id0, id0, id0, then id1.
- Req0 valid pattern 1,0,1,0,1,0,1 with a = b = {1,2,3,4} -> exactly 4 accepts, res_f = 30, grant held across the gaps.
- Reset low after 2 accepted beats of a=b=5 -> outputs at reset values within the same cycle, no res_valid. A following vector a = b = {1,1,1,1} gives res_f = 4.
